// File: rtl/corr_pair_sequencer.sv
// corr_pair_sequencer: drives ordered (first, second) vector pairs into a DUT, from an exhaustive sweep or a Galois LFSR,
// with a trigger window on the second vector and a registered capture of the DUT response at the end of each pair.
module corr_pair_sequencer #(
  parameter int          IN_SIZE  = 8,
  parameter int          OUT_SIZE = 8,
  parameter int          SIM      = 16,
  parameter int          HOLD     = 1,
  parameter logic [31:0] SEED     = 32'h1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic                              abort_i,
  input  logic                              mode_i,
  input  logic [OUT_SIZE-1:0]               dut_out_i,
  output logic [IN_SIZE-1:0]                in_vec_o,
  output logic                              trig_o,
  output logic                              busy_o,
  output logic                              pair_valid_o,
  output logic [IN_SIZE-1:0]                pair_first_o,
  output logic [IN_SIZE-1:0]                pair_second_o,
  output logic [OUT_SIZE-1:0]               out_cap_o,
  output logic [$clog2(SIM*SIM):0]          pair_idx_o,
  output logic                              done_o
);
  localparam int CW = $clog2(SIM) + 1;
  localparam int PW = $clog2(SIM*SIM) + 1;
  localparam int HW = $clog2(HOLD) + 1;
  localparam logic [31:0] POLY    = 32'h80200003;
  localparam logic [31:0] SEED_E  = (SEED == 32'h0) ? 32'h1 : SEED;
  // The first vector of a run is loaded on the start edge, so the seed is stepped once up front.
  localparam logic [31:0] SEED_NX = {1'b0, SEED_E[31:1]} ^ (SEED_E[0] ? POLY : 32'h0);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       i_q, j_q, i_d, j_d;
  logic [PW-1:0]       cnt_q;
  logic [HW-1:0]       hold_q;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                mode_q, hold_end, last_pair;
  logic [IN_SIZE-1:0]  first_q, in_vec_q, pair_first_q, pair_second_q;
  logic [OUT_SIZE-1:0] out_cap_q;
  logic [PW-1:0]       pair_idx_q;
  logic                trig_q, busy_q, pair_valid_q, done_q;

  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
    j_d       = (j_q == CW'(SIM-1)) ? '0 : j_q + 1'b1;
    i_d       = (j_q == CW'(SIM-1)) ? i_q + 1'b1 : i_q;
    hold_end  = hold_q == HW'(HOLD-1);
    last_pair = cnt_q == PW'(SIM*SIM-1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      lfsr_q        <= SEED_E;
      mode_q        <= 1'b0;
      first_q       <= '0;
      in_vec_q      <= '0;
      trig_q        <= 1'b0;
      busy_q        <= 1'b0;
      pair_valid_q  <= 1'b0;
      pair_first_q  <= '0;
      pair_second_q <= '0;
      out_cap_q     <= '0;
      pair_idx_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      pair_valid_q <= 1'b0;
      done_q       <= 1'b0;
      if (abort_i && busy_q) begin
        state_q  <= IDLE;
        in_vec_q <= '0;
        trig_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start_i) begin
            state_q  <= FIRST;
            mode_q   <= mode_i;
            i_q      <= '0;
            j_q      <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            lfsr_q   <= SEED_NX;
            in_vec_q <= mode_i ? SEED_NX[IN_SIZE-1:0] : '0;
            busy_q   <= 1'b1;
          end
          FIRST: if (hold_end) begin
            state_q  <= SECOND;
            hold_q   <= '0;
            trig_q   <= 1'b1;
            first_q  <= in_vec_q;
            in_vec_q <= mode_q ? lfsr_d[IN_SIZE-1:0] : IN_SIZE'(j_q);
            if (mode_q) lfsr_q <= lfsr_d;
          end else hold_q <= hold_q + 1'b1;
          SECOND: if (hold_end) begin
            hold_q        <= '0;
            trig_q        <= 1'b0;
            pair_valid_q  <= 1'b1;
            pair_first_q  <= first_q;
            pair_second_q <= in_vec_q;
            out_cap_q     <= dut_out_i;
            pair_idx_q    <= cnt_q;
            if (last_pair) begin
              state_q  <= DONE;
              in_vec_q <= '0;
              busy_q   <= 1'b0;
            end else begin
              state_q  <= FIRST;
              cnt_q    <= cnt_q + 1'b1;
              i_q      <= i_d;
              j_q      <= j_d;
              in_vec_q <= mode_q ? lfsr_d[IN_SIZE-1:0] : IN_SIZE'(i_d);
              if (mode_q) lfsr_q <= lfsr_d;
            end
          end else hold_q <= hold_q + 1'b1;
          DONE: begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

  assign in_vec_o      = in_vec_q;
  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign pair_valid_o  = pair_valid_q;
  assign pair_first_o  = pair_first_q;
  assign pair_second_o = pair_second_q;
  assign out_cap_o     = out_cap_q;
  assign pair_idx_o    = pair_idx_q;
  assign done_o        = done_q;
endmodule

// File: tb/tb_corr_pair_sequencer.sv
// tb_corr_pair_sequencer: directed runs with an expected-pair queue checked by an independent pair_valid monitor.
module tb_corr_pair_sequencer;
  localparam int H = 2;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0, abort_i = 1'b0, mode_i = 1'b0;
  logic [7:0] dut_out_i, in_vec_o, pair_first_o, pair_second_o, out_cap_o;
  logic [4:0] pair_idx_o;
  logic       trig_o, busy_o, pair_valid_o, done_o;

  typedef struct {
    logic [7:0] f;
    logic [7:0] s;
    logic [7:0] cap;
    int         idx;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk = 0, n_fail = 0, done_cnt = 0, exp_done = 0;

  corr_pair_sequencer #(.IN_SIZE(8), .OUT_SIZE(8), .SIM(S), .HOLD(H), .SEED(32'h1)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .dut_out_i(dut_out_i), .in_vec_o(in_vec_o), .trig_o(trig_o), .busy_o(busy_o),
    .pair_valid_o(pair_valid_o), .pair_first_o(pair_first_o), .pair_second_o(pair_second_o),
    .out_cap_o(out_cap_o), .pair_idx_o(pair_idx_o), .done_o(done_o)
  );

  assign dut_out_i = ~in_vec_o;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pair_valid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pair_valid: got pair_idx %0d required no pair", pair_idx_o);
      end else begin
        e = q.pop_front();
        chk("pair_first", 32'(pair_first_o), 32'(e.f));
        chk("pair_second", 32'(pair_second_o), 32'(e.s));
        chk("out_cap", 32'(out_cap_o), 32'(e.cap));
        chk("pair_idx", 32'(pair_idx_o), e.idx);
      end
    end
    if (done_o) done_cnt++;
  end

  function automatic logic [31:0] step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic push_full(input int n);
    for (int p = 0; p < n; p++) q.push_back('{8'(p / S), 8'(p % S), ~8'(p % S), p});
  endtask

  task automatic push_random();
    logic [31:0] l = 32'h1;
    logic [7:0] f;
    for (int p = 0; p < S*S; p++) begin
      l = step(l);
      f = l[7:0];
      l = step(l);
      q.push_back('{f, l[7:0], ~l[7:0], p});
    end
  endtask

  task automatic do_start(input logic m);
    start_i = 1'b1;
    mode_i  = m;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic full_cycles();
    for (int p = 0; p < S*S; p++) begin
      for (int h = 0; h < H; h++) begin
        chk("first_vec", 32'(in_vec_o), p / S);
        chk("first_trig", 32'(trig_o), 0);
        chk("first_busy", 32'(busy_o), 1);
        @(negedge clk);
      end
      for (int h = 0; h < H; h++) begin
        chk("second_vec", 32'(in_vec_o), p % S);
        chk("second_trig", 32'(trig_o), 1);
        chk("second_busy", 32'(busy_o), 1);
        @(negedge clk);
      end
    end
    chk("done_state_busy", 32'(busy_o), 0);
    chk("done_state_trig", 32'(trig_o), 0);
    chk("done_state_early_done", 32'(done_o), 0);
    @(negedge clk);
    exp_done++;
    chk("done_pulse", 32'(done_o), 1);
    chk("done_busy", 32'(busy_o), 0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    exp_done++;
    chk("done_seen", 32'(done_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_vec", 32'(in_vec_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_trig", 32'(trig_o), 0);
    chk("rst_valid", 32'(pair_valid_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_idx", 32'(pair_idx_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exhaustive sweep with per-cycle vector/trigger checks
    push_full(S*S);
    do_start(1'b0);
    full_cycles();
    @(negedge clk);
    chk("done_one_cycle", 32'(done_o), 0);
    chk("full_queue_empty", q.size(), 0);
    chk("full_done_cnt", done_cnt, exp_done);

    // Random mode twice: identical vectors each run
    for (int r = 0; r < 2; r++) begin
      push_random();
      do_start(1'b1);
      chk("rand_first_vec", 32'(in_vec_o), 32'h03);
      repeat (H) @(negedge clk);
      chk("rand_second_vec", 32'(in_vec_o), 32'h02);
      chk("rand_second_trig", 32'(trig_o), 1);
      repeat (H) @(negedge clk);
      chk("rand_pair1_first", 32'(in_vec_o), 32'h01);
      wait_done(400);
      @(negedge clk);
      chk("rand_queue_empty", q.size(), 0);
      chk("rand_done_cnt", done_cnt, exp_done);
    end

    // Abort during SECOND of pair 5
    push_full(5);
    do_start(1'b0);
    repeat (5*2*H + H) @(negedge clk);
    chk("abort_pre_trig", 32'(trig_o), 1);
    chk("abort_pre_vec", 32'(in_vec_o), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_vec", 32'(in_vec_o), 0);
    chk("abort_trig", 32'(trig_o), 0);
    chk("abort_idx", 32'(pair_idx_o), 4);
    chk("abort_keep_first", 32'(pair_first_o), 1);
    chk("abort_keep_second", 32'(pair_second_o), 0);
    chk("abort_keep_cap", 32'(out_cap_o), 32'hff);
    repeat (80) @(negedge clk);
    chk("abort_no_done", done_cnt, exp_done);
    chk("abort_idx_held", 32'(pair_idx_o), 4);
    chk("abort_queue_empty", q.size(), 0);

    // Asynchronous reset in FIRST of pair 6, then a clean restart
    push_full(6);
    do_start(1'b0);
    repeat (6*2*H) @(negedge clk);
    chk("pre_rst_vec", 32'(in_vec_o), 1);
    chk("pre_rst_busy", 32'(busy_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vec", 32'(in_vec_o), 0);
    chk("async_rst_busy", 32'(busy_o), 0);
    chk("async_rst_valid", 32'(pair_valid_o), 0);
    chk("async_rst_idx", 32'(pair_idx_o), 0);
    chk("async_rst_first", 32'(pair_first_o), 0);
    chk("async_rst_second", 32'(pair_second_o), 0);
    chk("async_rst_cap", 32'(out_cap_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_queue_empty", q.size(), 0);
    push_full(S*S);
    do_start(1'b0);
    full_cycles();

    // start held high through an entire run
    @(negedge clk);
    push_full(S*S);
    start_i = 1'b1;
    mode_i  = 1'b0;
    @(negedge clk);
    full_cycles();
    @(negedge clk);
    chk("held_restart_busy", 32'(busy_o), 1);
    chk("held_restart_vec", 32'(in_vec_o), 0);
    chk("held_restart_trig", 32'(trig_o), 0);
    start_i = 1'b0;
    push_full(S*S);
    full_cycles();
    @(negedge clk);
    chk("final_queue_empty", q.size(), 0);
    chk("final_done_cnt", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/corr_pair_sequencer.md
# corr_pair_sequencer

Synthesizable stimulus sequencer for power-correlation characterisation of the gate-level `interface` DUT. It generates ordered pairs of input vectors (first, second), either as an exhaustive i×j sweep or from a reproducible LFSR. It asserts a trigger window while the second vector is applied, and captures the DUT response at the end of each pair. It sits between the bench/control logic and the DUT `in`/`out` ports, and replaces per-run hand-written vector loops.

## Interface
- `IN_SIZE`, 8, DUT input width.
- `OUT_SIZE`, 8, DUT output width.
- `SIM`, 16, sweep size per dimension; total pairs = SIM*SIM; range 1..2**IN_SIZE.
- `HOLD`, 1, clock cycles each vector is held, ≥1.
- `SEED`, 32'h1, LFSR seed; a zero value is treated as 32'h1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a run when sampled high in IDLE.
- `abort`  in  1  terminates a run when sampled high while busy.
- `mode`  in  1  0 = FULL (exhaustive), 1 = RANDOM; sampled only with an accepted `start`.
- `dut_out`  in  OUT_SIZE  DUT response.
- `in_vec`  out  IN_SIZE  vector driven to the DUT.
- `trig`  out  1  high while the second vector of a pair is applied.
- `busy`  out  1  high in FIRST/SECOND.
- `pair_valid`  out  1  one-cycle pulse marking a completed pair.
- `pair_first`, `pair_second`  out  IN_SIZE each  vectors of the completed pair.
- `out_cap`  out  OUT_SIZE  `dut_out` captured at the end of SECOND.
- `pair_idx`  out  clog2(SIM*SIM)+1  index of the completed pair, 0-based.
- `done`  out  1  one-cycle pulse after the last pair.

## Operation
- States: IDLE, FIRST, SECOND, DONE.
- Transitions:
  - IDLE→FIRST on `start`.
  - FIRST→SECOND after HOLD cycles.
  - SECOND→FIRST after HOLD cycles if pairs remain.
  - SECOND→DONE after the last pair.
  - DONE→IDLE unconditionally.
- Any busy state →IDLE on `abort`. `abort` takes priority over all other transitions.
- On an accepted `start`: latch `mode`; clear i, j and the pair counter; load lfsr ← SEED.
- FULL mode: the first vector is i and the second is j, each truncated/zero-extended to IN_SIZE. j increments after every pair; when j wraps SIM-1→0, i increments. The last pair is (SIM-1, SIM-1).
- RANDOM mode: Galois LFSR, lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 0). Each vector load sets in_vec ← lfsr_next[IN_SIZE-1:0] and lfsr ← lfsr_next, giving two steps per pair. Both mode runs produce SIM*SIM pairs.
- `start` while busy or in DONE: ignored.
- `mode` changes mid-run: ignored.
- `abort`:
  - No `pair_valid` and no `done` for the interrupted pair.
  - `in_vec`, `trig` and `busy` return to 0 on the next edge.
  - `pair_*` and `out_cap` keep their last values.
- Reset values: all outputs 0, state IDLE, lfsr = SEED.
- `rst_n` low mid-run forces reset values immediately, independent of `clk`.

## Timing
- `start` sampled at edge k:
  - At k+1, FIRST begins, `in_vec` = first vector, `busy` = 1.
  - At k+1+HOLD, SECOND begins, `in_vec` = second vector, `trig` = 1.
- Capture at the edge ending SECOND (k+1+2·HOLD):
  - `out_cap` ← `dut_out`.
  - `pair_first`/`pair_second`/`pair_idx` are updated.
  - `pair_valid` = 1 for that one cycle.
  - The next pair's FIRST starts in the same cycle, with no gap.
- A full run takes 2·HOLD·SIM² busy cycles.
- `done` pulses in the cycle after the last `pair_valid`. `busy` = 0 in DONE.
- `trig` is high for exactly HOLD cycles per pair and is never high in FIRST, IDLE or DONE.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- FULL, IN_SIZE=2, SIM=2, HOLD=1, `start` at edge 0:
  - `in_vec` sequence 0,0,0,1,1,0,1,1 on cycles 1–8.
  - `trig` high on even cycles.
  - `pair_valid` at cycles 3,5,7,9 with (0,0),(0,1),(1,0),(1,1) and pair_idx 0–3.
  - `done` at cycle 10.
- RANDOM, IN_SIZE=8, SEED=1:
  - First pair (8'h03, 8'h02).
  - A second run after `done` repeats identical vectors.
- HOLD=3, dut_out = ~in_vec loopback:
  - Each vector held 3 cycles; `trig` high 3 cycles per pair.
  - out_cap == ~pair_second for every pair.
- `abort` asserted during the SECOND of pair 5 (SIM=4):
  - Next cycle: `busy` = 0, `in_vec` = 0.
  - No further `pair_valid`, no `done`; pair_idx remains 4.
- `rst_n` pulsed low mid-FIRST between clock edges:
  - All outputs go to 0 immediately.
  - After release, `start` runs from pair (0,0) again.
- `start` held high throughout a FULL SIM=2 run:
  - The run is not restarted.
  - A new run begins only after the cycle following DONE, i.e. once the block is back in IDLE.
